// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART core.
// Oversampling constants, parity modes, FSM encodings and divider helper.
package uart_pkg;

    localparam int OS_RATE = 16;
    localparam int OS_MID  = 7;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Rounded clocks per oversample tick, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + 8 * baud) / (16 * baud);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit full/empty and a held last-head output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_last;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Once drained, the output keeps the most recently popped head.
    assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transceiver with 16x oversampled RX and TX/RX FIFOs.
// Define UART_LOOPBACK_EN to enable the internal TX->RX loopback input.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_par_err,
    output logic                 rx_frm_err,
    output logic                 rx_overrun,
    output logic                 tx_busy,
    input  logic                 loopback,
    output logic                 tx,
    input  logic                 rx
);

    localparam int          DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam parity_e     PAR       = parity_e'(PARITY_MODE[1:0]);
    localparam logic        PAR_EN    = (PAR != PAR_NONE);
    localparam logic        PAR_INV   = (PAR == PAR_ODD);
    localparam logic [3:0]  TICK_LAST = 4'(OS_RATE - 1);
    localparam logic [3:0]  TICK_MID  = 4'(OS_MID);
    localparam logic [3:0]  DBIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  SBIT_LAST = 4'(STOP_BITS - 1);

    logic [15:0] r_div_cnt;
    logic        w_os_tick;

    assign w_os_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_div_cnt <= '0;
        else if (w_os_tick) r_div_cnt <= '0;
        else                r_div_cnt <= r_div_cnt + 16'd1;
    end

    logic                 w_txf_full;
    logic                 w_txf_empty;
    logic                 w_txf_pop;
    logic [DATA_BITS-1:0] w_txf_data;

    assign tx_ready = !w_txf_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (tx_valid && tx_ready),
        .i_wdata (tx_data),
        .i_pop   (w_txf_pop),
        .o_rdata (w_txf_data),
        .o_full  (w_txf_full),
        .o_empty (w_txf_empty)
    );

    tx_state_e            r_tx_state, w_tx_nxt;
    logic [3:0]           r_tx_tick, w_tx_tick_n;
    logic [3:0]           r_tx_bit, w_tx_bit_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx_par, w_tx_par_n;
    logic                 w_ser;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_nxt;
            r_tx_tick  <= w_tx_tick_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_par   <= w_tx_par_n;
        end
    end

    always_comb begin
        w_tx_nxt     = r_tx_state;
        w_tx_tick_n  = r_tx_tick;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_par_n   = r_tx_par;
        w_txf_pop    = 1'b0;
        if (r_tx_state == TX_IDLE) begin
            w_txf_pop = w_os_tick && !w_txf_empty;
        end else if (w_os_tick) begin
            w_tx_tick_n = r_tx_tick + 4'd1;
            if (r_tx_tick == TICK_LAST) begin
                unique case (r_tx_state)
                    TX_START: begin
                        w_tx_nxt   = TX_DATA;
                        w_tx_bit_n = '0;
                    end
                    TX_DATA: begin
                        w_tx_shift_n = r_tx_shift >> 1;
                        w_tx_bit_n   = r_tx_bit + 4'd1;
                        if (r_tx_bit == DBIT_LAST) begin
                            w_tx_nxt   = PAR_EN ? TX_PARITY : TX_STOP;
                            w_tx_bit_n = '0;
                        end
                    end
                    TX_PARITY: begin
                        w_tx_nxt   = TX_STOP;
                        w_tx_bit_n = '0;
                    end
                    TX_STOP: begin
                        w_tx_bit_n = r_tx_bit + 4'd1;
                        if (r_tx_bit == SBIT_LAST) begin
                            w_tx_nxt  = TX_IDLE;
                            w_txf_pop = !w_txf_empty;
                        end
                    end
                    default: w_tx_nxt = TX_IDLE;
                endcase
            end
        end
        // Loading straight from STOP keeps consecutive frames gapless.
        if (w_txf_pop) begin
            w_tx_nxt     = TX_START;
            w_tx_tick_n  = '0;
            w_tx_bit_n   = '0;
            w_tx_shift_n = w_txf_data;
            w_tx_par_n   = (^w_txf_data) ^ PAR_INV;
        end
    end

    always_comb begin
        w_ser = 1'b1;
        unique case (r_tx_state)
            TX_START:  w_ser = 1'b0;
            TX_DATA:   w_ser = r_tx_shift[0];
            TX_PARITY: w_ser = r_tx_par;
            default:   w_ser = 1'b1;
        endcase
    end

    assign tx_busy = (r_tx_state != TX_IDLE) || !w_txf_empty;

    logic w_rx_in;
`ifdef UART_LOOPBACK_EN
    assign w_rx_in = loopback ? w_ser : rx;
    assign tx      = loopback ? 1'b1 : w_ser;
`else
    logic w_unused_loopback;
    assign w_unused_loopback = loopback;
    assign w_rx_in = rx;
    assign tx      = w_ser;
`endif

    logic [1:0] r_sync;
    logic       w_line;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], w_rx_in};
    end

    assign w_line = r_sync[1];

    rx_state_e            r_rx_state, w_rx_nxt;
    logic [3:0]           r_rx_tick, w_rx_tick_n;
    logic [3:0]           r_rx_bit, w_rx_bit_n;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
    logic                 r_rx_pbit, w_rx_pbit_n;
    logic                 r_rx_armed, w_rx_armed_n;
    logic                 w_rx_wr;
    logic                 w_rx_perr;
    logic                 r_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_pbit  <= 1'b0;
            r_rx_armed <= 1'b0;
        end else begin
            r_rx_state <= w_rx_nxt;
            r_rx_tick  <= w_rx_tick_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_pbit  <= w_rx_pbit_n;
            r_rx_armed <= w_rx_armed_n;
        end
    end

    always_comb begin
        w_rx_nxt     = r_rx_state;
        w_rx_tick_n  = r_rx_tick;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_pbit_n  = r_rx_pbit;
        w_rx_armed_n = r_rx_armed;
        w_rx_wr      = 1'b0;
        // A start is only taken after the line has been seen high.
        if (r_rx_state == RX_IDLE) begin
            if (w_line) begin
                w_rx_armed_n = 1'b1;
            end else if (r_rx_armed) begin
                w_rx_nxt     = RX_START;
                w_rx_tick_n  = '0;
                w_rx_bit_n   = '0;
                w_rx_armed_n = 1'b0;
            end
        end else if (w_os_tick) begin
            w_rx_tick_n = r_rx_tick + 4'd1;
            unique case (r_rx_state)
                RX_START: begin
                    if (r_rx_tick == TICK_MID && w_line) begin
                        w_rx_nxt = RX_IDLE;
                    end else if (r_rx_tick == TICK_LAST) begin
                        w_rx_nxt   = RX_DATA;
                        w_rx_bit_n = '0;
                    end
                end
                RX_DATA: begin
                    if (r_rx_tick == TICK_MID)
                        w_rx_shift_n = {w_line, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_tick == TICK_LAST) begin
                        w_rx_bit_n = r_rx_bit + 4'd1;
                        if (r_rx_bit == DBIT_LAST)
                            w_rx_nxt = PAR_EN ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (r_rx_tick == TICK_MID)  w_rx_pbit_n = w_line;
                    if (r_rx_tick == TICK_LAST) w_rx_nxt = RX_STOP;
                end
                RX_STOP: begin
                    if (r_rx_tick == TICK_MID) begin
                        w_rx_wr  = 1'b1;
                        w_rx_nxt = RX_IDLE;
                    end
                end
                default: w_rx_nxt = RX_IDLE;
            endcase
        end
    end

    assign w_rx_perr = PAR_EN &&
                       (r_rx_pbit != ((^r_rx_shift) ^ PAR_INV));

    logic                 w_rxf_full;
    logic                 w_rxf_empty;
    logic                 w_rx_pop;
    logic [DATA_BITS+1:0] w_rxf_data;

    assign rx_valid = !w_rxf_empty;
    assign w_rx_pop = rx_valid && rx_ready;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_rx_wr),
        .i_wdata ({w_rx_perr, !w_line, r_rx_shift}),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rxf_data),
        .o_full  (w_rxf_full),
        .o_empty (w_rxf_empty)
    );

    assign rx_par_err = w_rxf_data[DATA_BITS+1];
    assign rx_frm_err = w_rxf_data[DATA_BITS];
    assign rx_data    = w_rxf_data[DATA_BITS-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_overrun <= 1'b0;
        else          r_overrun <= w_rx_wr && w_rxf_full && !w_rx_pop;
    end

    assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: 8E1, 16 MHz / 1 Mbaud, FIFO depth 4.
// The loopback case is built only when UART_LOOPBACK_EN is defined.
module tb_uart_fifo_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_par_err;
    logic       rx_frm_err;
    logic       rx_overrun;
    logic       tx_busy;
    logic       loopback;
    logic       tx;
    logic       rx;
    logic       r_wire;
    logic       r_rx_drv;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_cnt  = 0;

    typedef struct {
        logic [7:0] din;
        logic       pbit;
        logic       sbit;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs [8];

    assign rx = r_wire ? tx : r_rx_drv;

    uart_fifo_core #(
        .CLK_FREQ    (16_000_000),
        .BAUD_RATE   (1_000_000),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_MODE (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .rx_overrun (rx_overrun),
        .tx_busy    (tx_busy),
        .loopback   (loopback),
        .tx         (tx),
        .rx         (rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_overrun) ov_cnt++;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic pb,
                              input logic sb);
        r_rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            r_rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        r_rx_drv = pb;
        repeat (16) @(negedge clk);
        r_rx_drv = sb;
        repeat (16) @(negedge clk);
        r_rx_drv = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic wait_rxv(input string name);
        int k;
        k = 0;
        while (!rx_valid && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (!rx_valid) check({name, ".timeout"}, 0, 1);
    endtask

    task automatic pop_check(input string name,
                             input logic [7:0] d,
                             input logic pe,
                             input logic fe);
        wait_rxv(name);
        check({name, ".data"}, rx_data, d);
        check({name, ".par"}, rx_par_err, pe);
        check({name, ".frm"}, rx_frm_err, fe);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_low(input string name);
        int k;
        k = 0;
        while (tx !== 1'b0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        check({name, ".start"}, tx, 0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (tx_busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({name, ".idle"}, tx_busy, 0);
    endtask

    logic       exp1 [11];
    logic [7:0] exp2 [3];

    initial begin
        int base;
        int bad;
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        exp1 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        exp2 = '{8'h00, 8'hFF, 8'h3C};

        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        loopback = 1'b0;
        r_wire   = 1'b0;
        r_rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.tx", tx, 1);
        check("rst.tx_ready", tx_ready, 1);
        check("rst.tx_busy", tx_busy, 0);
        check("rst.rx_valid", rx_valid, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst.rx_overrun", rx_overrun, 0);
        check("rst.rx_data", rx_data, 0);
        check("rst.par", rx_par_err, 0);
        check("rst.frm", rx_frm_err, 0);

        // 0xA5 framed as 8E1
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_tx_low("t1");
        repeat (7) @(negedge clk);
        check("t1.busy_mid", tx_busy, 1);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t1.bit%0d", i), tx, exp1[i]);
            repeat (16) @(negedge clk);
        end
        check("t1.busy_end", tx_busy, 0);
        check("t1.tx_idle", tx, 1);

        // Back-to-back frames through an external tx->rx wire
        r_wire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data  = exp2[i];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            pop_check($sformatf("t2.b%0d", i), exp2[i], 1'b0, 1'b0);
        wait_idle("t2");
        r_wire = 1'b0;
        repeat (20) @(negedge clk);

        // Directed RX frames, including parity and stop errors
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].din, vecs[i].pbit, vecs[i].sbit);
            pop_check($sformatf("t3.v%0d", i), vecs[i].exp_d,
                      vecs[i].exp_pe, vecs[i].exp_fe);
        end

        // Short low glitch must not create a frame
        r_rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        r_rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("t5.no_write", rx_valid, 0);
        send_frame(8'hA5, 1'b0, 1'b1);
        pop_check("t5.after", 8'hA5, 1'b0, 1'b0);

        // Overrun: 5 frames into a depth-4 FIFO with no pops
        base = ov_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        check("t4.no_ov_yet", ov_cnt - base, 0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("t4.ov_pulses", ov_cnt - base, 1);
        pop_check("t4.e0", 8'h11, 1'b0, 1'b0);
        pop_check("t4.e1", 8'h22, 1'b0, 1'b0);
        pop_check("t4.e2", 8'h33, 1'b0, 1'b0);
        pop_check("t4.e3", 8'h44, 1'b0, 1'b0);
        check("t4.empty", rx_valid, 0);
        check("t4.hold", rx_data, 8'h44);

        // Reset in the middle of a TX data phase
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_tx_low("t6");
        repeat (40) @(negedge clk);
        check("t6.pre_low", tx, 0);
        reset_n = 1'b0;
        #1;
        check("t6.tx_async", tx, 1);
        check("t6.tx_ready", tx_ready, 1);
        check("t6.tx_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("t6.no_residual", bad, 0);
        check("t6.busy_after", tx_busy, 0);
        check("t6.rx_valid", rx_valid, 0);

`ifdef UART_LOOPBACK_EN
        // Internal loopback keeps the pin idle
        loopback = 1'b1;
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 400 && !rx_valid; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check("t7.tx_high", bad, 0);
        pop_check("t7.rx", 8'h81, 1'b0, 1'b0);
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
